// File: rtl/sc_stream_decoder_if.sv
// sc_stream_decoder_if
//   Groups the control, stream-input and result signals of sc_stream_decoder.
//   The master side drives the inputs: start, abort, cont, len_sel, in_bit,
//   in_valid and result_ack. The slave side (the decoder) drives result,
//   result_valid, busy, overrun and dbg_state.
//
//   Handshake semantics:
//     - in_bit/in_valid: one-way stream, no backpressure. Each edge with
//       in_valid=1 while busy delivers one sample.
//     - result/result_valid/result_ack: a result transfers on an edge where
//       result_valid=1 and result_ack=1. result stays stable while
//       result_valid=1 and no ack has been seen. A new result may still
//       overwrite an unacknowledged one; overrun then goes high.
//     - dbg_state: current FSM state (0 = IDLE, 1 = RUN).
interface sc_stream_decoder_if #(
  parameter int RES_W = 8
);
  logic             start;
  logic             abort;
  logic             cont;
  logic [1:0]       len_sel;
  logic             in_bit;
  logic             in_valid;
  logic [RES_W-1:0] result;
  logic             result_valid;
  logic             result_ack;
  logic             busy;
  logic             overrun;
  logic             dbg_state;

  modport master (
    output start, abort, cont, len_sel, in_bit, in_valid, result_ack,
    input  result, result_valid, busy, overrun, dbg_state
  );

  modport slave (
    input  start, abort, cont, len_sel, in_bit, in_valid, result_ack,
    output result, result_valid, busy, overrun, dbg_state
  );
endinterface

// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder
//   Turns a stochastic bitstream back into a binary value. It counts the ones
//   over a window of N valid samples (N = 32/64/128/256) and scales the count
//   to 8 bits, saturating at 255.
//   Ports:
//     clk    - single clock, all state changes on posedge
//     rst_n  - asynchronous active-low reset
//     bus    - sc_stream_decoder_if.slave (control, stream in, result out)
//   Every output comes straight from a flop, so no input reaches an output
//   combinationally.
module sc_stream_decoder #(
  parameter int RES_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sc_stream_decoder_if.slave   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       len_q;
  logic [8:0]       sample_cnt;
  logic [8:0]       ones_cnt;
  logic [RES_W-1:0] result_q;
  logic             result_valid_q;
  logic             overrun_q;

  // Next-sample values and the window-end decode.
  logic [8:0]       n_val;
  logic [8:0]       sample_nxt;
  logic [8:0]       ones_nxt;
  logic [11:0]      scaled;
  logic [RES_W-1:0] result_nxt;
  logic             win_end;

  always_comb begin
    n_val      = 9'd32 << len_q;
    sample_nxt = sample_cnt + 9'd1;
    ones_nxt   = ones_cnt + {8'd0, bus.in_bit};
    // Scale the count so every window length maps onto the 0..256 range.
    // Only an all-ones window reaches 256, which saturates to 255.
    scaled     = {3'd0, ones_nxt} << (2'd3 - len_q);
    result_nxt = (scaled > 12'd255) ? {RES_W{1'b1}} : RES_W'(scaled);
    win_end    = bus.in_valid && (sample_nxt == n_val);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      len_q          <= 2'd0;
      sample_cnt     <= 9'd0;
      ones_cnt       <= 9'd0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      // The consumer may ack in any state. A window end later in this block
      // takes precedence and sets result_valid again.
      if (result_valid_q && bus.result_ack) begin
        result_valid_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            len_q      <= bus.len_sel;
            sample_cnt <= 9'd0;
            ones_cnt   <= 9'd0;
            overrun_q  <= 1'b0;
            state      <= RUN;
          end
        end

        RUN: begin
          if (bus.abort) begin
            // An abort wins over a coincident window end. The result side
            // is left untouched.
            sample_cnt <= 9'd0;
            ones_cnt   <= 9'd0;
            state      <= IDLE;
          end else if (win_end) begin
            result_q       <= result_nxt;
            result_valid_q <= 1'b1;
            if (result_valid_q && !bus.result_ack) begin
              overrun_q <= 1'b1;
            end
            // Clearing here lets a sample on the very next edge start the
            // new window in continuous mode, with no gap cycle.
            sample_cnt <= 9'd0;
            ones_cnt   <= 9'd0;
            if (!bus.cont) begin
              state <= IDLE;
            end
          end else if (bus.in_valid) begin
            sample_cnt <= sample_nxt;
            ones_cnt   <= ones_nxt;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = (state == RUN);
  assign bus.overrun      = overrun_q;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// tb_sc_stream_decoder
//   Directed bench for sc_stream_decoder. The expected values are worked out
//   by hand from the decode rule: result = min(ones << (3 - len_sel), 255).
module tb_sc_stream_decoder;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sc_stream_decoder_if #(.RES_W(8)) bus ();

  sc_stream_decoder #(.RES_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge. Inputs are set before the edge and outputs are read
  // 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_win(input logic [1:0] len, input logic c);
    bus.start   = 1'b1;
    bus.len_sel = len;
    bus.cont    = c;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic send(input logic b);
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    tick();
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
  endtask

  task automatic ack();
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) send(1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int nvalid;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.cont       = 1'b0;
    bus.len_sel    = 2'd0;
    bus.in_bit     = 1'b0;
    bus.in_valid   = 1'b0;
    bus.result_ack = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_result", 32'(bus.result), 0);
    check("rst_rvalid", 32'(bus.result_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_overrun", 32'(bus.overrun), 0);
    rst_n = 1'b1;
    tick();

    // Saturation: len 0, 32 ones gives 32<<3 = 256, which saturates to 255.
    start_win(2'd0, 1'b0);
    check("sat_busy_run", 32'(bus.busy), 1);
    send_ones(31);
    check("sat_not_early", 32'(bus.result_valid), 0);
    send(1'b1);
    check("sat_result", 32'(bus.result), 255);
    check("sat_rvalid", 32'(bus.result_valid), 1);
    check("sat_busy_idle", 32'(bus.busy), 0);
    repeat (3) tick();
    check("hold_rvalid", 32'(bus.result_valid), 1);
    check("hold_result", 32'(bus.result), 255);
    ack();
    check("ack_clears", 32'(bus.result_valid), 0);

    // Scaling, len 3: 128 ones in 256 samples gives 128. len_sel is changed
    // mid-window and must have no effect.
    start_win(2'd3, 1'b0);
    for (int i = 0; i < 255; i++) begin
      if (i == 40) bus.len_sel = 2'd0;
      send(i[0] ? 1'b0 : 1'b1);
    end
    check("len3_not_early", 32'(bus.result_valid), 0);
    check("len3_still_busy", 32'(bus.busy), 1);
    send(1'b0);
    check("len3_result", 32'(bus.result), 128);
    ack();
    // len 1: 32 ones in 64 samples, 32<<2 = 128
    start_win(2'd1, 1'b0);
    for (int i = 0; i < 64; i++) send(i[0] ? 1'b0 : 1'b1);
    check("len1_result", 32'(bus.result), 128);
    check("len1_rvalid", 32'(bus.result_valid), 1);
    ack();

    // Gaps: 20 ones then 12 zeros, in_valid low on every third cycle.
    // Result is 20<<3 = 160.
    start_win(2'd0, 1'b0);
    nvalid = 0;
    for (int c = 0; nvalid < 32; c++) begin
      if (c % 3 == 2) begin
        tick();
      end else begin
        if (nvalid == 31) check("gap_not_early", 32'(bus.result_valid), 0);
        send(nvalid < 20 ? 1'b1 : 1'b0);
        nvalid++;
      end
    end
    check("gap_result", 32'(bus.result), 160);
    check("gap_rvalid", 32'(bus.result_valid), 1);
    ack();

    // Continuous mode, no ack: the second result overruns the first.
    start_win(2'd0, 1'b1);
    send_ones(32);
    check("cont1_result", 32'(bus.result), 255);
    check("cont1_busy", 32'(bus.busy), 1);
    check("cont1_overrun", 32'(bus.overrun), 0);
    // The second window starts on the very next sample: 4 ones and 28 zeros
    // gives 4<<3 = 32.
    for (int i = 0; i < 32; i++) send(i < 4 ? 1'b1 : 1'b0);
    check("cont2_result", 32'(bus.result), 32);
    check("cont2_rvalid", 32'(bus.result_valid), 1);
    check("cont2_overrun", 32'(bus.overrun), 1);
    bus.cont = 1'b0;
    send_ones(32);
    check("cont3_idle", 32'(bus.busy), 0);
    check("overrun_sticky", 32'(bus.overrun), 1);

    // Continuous mode with an ack at each window end: overrun must stay 0.
    start_win(2'd0, 1'b1);
    check("start_clr_ovr", 32'(bus.overrun), 0);
    for (int w = 0; w < 3; w++) begin
      if (w == 2) bus.cont = 1'b0;
      send_ones(31);
      bus.result_ack = 1'b1;
      send(1'b1);
      bus.result_ack = 1'b0;
    end
    check("ackwin_overrun", 32'(bus.overrun), 0);
    check("ackwin_rvalid", 32'(bus.result_valid), 1);
    check("ackwin_idle", 32'(bus.busy), 0);

    // Abort at sample 10 of a 64-sample window. The held result (255,
    // unacked) must survive.
    start_win(2'd1, 1'b0);
    send_ones(10);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_rvalid", 32'(bus.result_valid), 1);
    check("abort_result", 32'(bus.result), 255);
    // An abort in IDLE has no effect.
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_idle_rv", 32'(bus.result_valid), 1);
    ack();
    start_win(2'd1, 1'b0);
    for (int i = 0; i < 64; i++) send(1'b0);
    check("zero_result", 32'(bus.result), 0);
    check("zero_rvalid", 32'(bus.result_valid), 1);

    // An abort coincident with the window end wins: no new result loads.
    ack();
    start_win(2'd0, 1'b0);
    send_ones(31);
    bus.abort = 1'b1;
    send(1'b1);
    bus.abort = 1'b0;
    check("abprio_rvalid", 32'(bus.result_valid), 0);
    check("abprio_result", 32'(bus.result), 0);
    check("abprio_busy", 32'(bus.busy), 0);

    // Asynchronous reset mid-window, between clock edges. First make
    // result, result_valid and overrun nonzero.
    start_win(2'd0, 1'b0);
    send_ones(32);
    start_win(2'd0, 1'b0);
    send_ones(32);
    check("pre_rst_overrun", 32'(bus.overrun), 1);
    start_win(2'd0, 1'b0);
    send_ones(10);
    #2 rst_n = 1'b0;
    #1;
    check("arst_result", 32'(bus.result), 0);
    check("arst_rvalid", 32'(bus.result_valid), 0);
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_overrun", 32'(bus.overrun), 0);
    #2 rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_no_res", 32'(bus.result_valid), 0);
    start_win(2'd0, 1'b0);
    check("post_rst_start", 32'(bus.busy), 1);
    send_ones(32);
    check("post_rst_result", 32'(bus.result), 255);
    check("post_rst_rvalid", 32'(bus.result_valid), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sc_stream_decoder.md
SC_STREAM_DECODER -- requirements
Module: sc_stream_decoder

Interface
REQ-001 Parameter: RES_W, default 8, width of the binary result (value 8 is the only supported value).
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  begin a decode window; sampled only in IDLE.
REQ-005 abort  input  1  cancel the window in progress.
REQ-006 cont  input  1  continuous mode; sampled at each window end.
REQ-007 len_sel  input  2  window length N = 32/64/128/256 for values 0/1/2/3.
REQ-008 in_bit  input  1  stochastic bitstream sample.
REQ-009 in_valid  input  1  in_bit is valid this cycle.
REQ-010 result  output  RES_W  decoded binary value.
REQ-011 result_valid  output  1  result is held and unacknowledged.
REQ-012 result_ack  input  1  consumer accepts the result.
REQ-013 busy  output  1  high while in RUN.
REQ-014 overrun  output  1  sticky flag: a result was lost.

Function
REQ-015 The block SHALL convert a stochastic bitstream back to binary by counting ones over N valid samples.
REQ-016 The FSM SHALL have two states: IDLE and RUN; busy = (state == RUN).
REQ-017 On start=1 in IDLE, the block SHALL:
  - latch len_sel into an internal N register;
  - clear the 9-bit sample counter and the 9-bit ones counter, and clear overrun;
  - enter RUN on the next edge.
REQ-018 start in RUN SHALL be ignored; a len_sel change in RUN SHALL have no effect until the next window.
REQ-019 In RUN, each edge with in_valid=1 SHALL increment the sample counter and add in_bit to the ones counter; in_valid=0 SHALL leave both counters unchanged.
REQ-020 Window end is the edge at which the accepted sample makes the sample count equal to N; this sample SHALL be included in the ones count.
REQ-021 At window end, result SHALL load min(ones << (3 - len_sel_latched), 255), and result_valid SHALL be set on that same edge (1-cycle latency from the last sample).
REQ-022 At window end with cont=1, the block SHALL clear both counters and stay in RUN, with no gap cycle; a sample on the next cycle belongs to the new window.
REQ-023 At window end with cont=0, the block SHALL return to IDLE.
REQ-024 result_valid SHALL stay high, with result stable, until an edge with result_ack=1, then clear.
REQ-025 If result_ack=1 and a new window end occur on the same edge, the new result SHALL load and result_valid SHALL remain 1; overrun is not set.
REQ-026 If a window end occurs while result_valid=1 and result_ack=0, the new result SHALL overwrite the held result and overrun SHALL be set.
REQ-027 overrun SHALL clear only on reset or on an accepted start.
REQ-028 abort=1 in RUN SHALL:
  - return the block to IDLE and clear the counters;
  - produce no result;
  - leave result, result_valid and overrun untouched.
REQ-029 abort SHALL take priority over a coincident window end.
REQ-030 abort in IDLE SHALL have no effect.
REQ-031 All outputs SHALL be registered; the block SHALL NOT place a combinational path from any input to any output.

Reset
REQ-032 While rst_n=0, the block SHALL immediately, independent of clk, set the following and hold them:
  - state = IDLE, counters = 0, latched N = 32;
  - result = 0, result_valid = 0, busy = 0, overrun = 0.
REQ-033 Reset asserted mid-window SHALL discard the partial count; no result is produced after reset release.
REQ-034 After rst_n rises, the first start SHALL be honoured on the first clk edge.

Verification
REQ-035 Saturation: len_sel=0, cont=0, 32 valid ones -> one edge after the last sample, result=255, result_valid=1, busy=0.
REQ-036 Scaling: len_sel=3, alternating 1/0 for 256 valid samples -> result=128; repeat with len_sel=1 and 64 samples -> result=128.
REQ-037 Gaps: len_sel=0, 20 ones and 12 zeros with in_valid=0 on every third cycle -> result=160, produced only after 32 valid samples.
REQ-038 Continuous and overrun: cont=1, len_sel=0, all-ones stream, result_ack held 0 -> two back-to-back results and overrun=1 after the second. Holding result_ack=1 at each window end instead -> overrun stays 0.
REQ-039 Abort: abort at sample 10 of a 64-sample window -> busy=0 next edge and result_valid unchanged. A following start with 64 zeros -> result=0.
REQ-040 Async reset: rst_n pulsed low mid-window, between clk edges -> all outputs 0 immediately. A start after release with 32 ones -> result=255.
